fifo_wr_framer: RTL



---
 rtl/fifo_wr_framer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_framer.sv
// Purpose: frames a source stream as SOF, 1..MAX_LEN payload words, XOR checksum into an async FIFO write port.
// Latency: SOF written one cycle after s_valid is seen in IDLE; writes are combinational, frame_done/trunc one cycle after the checksum write.
// Backpressure: fifo_full stalls every state except IDLE/DROP in place; s_ready drops with fifo_full while payload is forwarded.
// Optional: define FRAMER_STATS_EN for saturating frame_count / trunc_count statistics.
module fifo_wr_framer #(
  parameter int               Width   = 4,
  parameter int               MAX_LEN = 8,
  parameter logic [Width-1:0] SOF     = Width'(4'hA)
) (
  input  logic             Wr_clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [Width-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [Width-1:0] fifo_data,
  output logic             frame_done,
  output logic             trunc,
  output logic [7:0]       frame_count,
  output logic [7:0]       trunc_count
);

  localparam logic [7:0] MaxLenC = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DROP, CSUM} state_t;

  state_t           state, state_nxt;
  logic [Width-1:0] csum_q;
  logic [7:0]       count_q;
  logic             trunc_flag_q;
  logic             frame_done_q;
  logic             trunc_q;

  logic xfer;
  logic hdr_wr;
  logic csum_wr;
  logic at_max;

  assign xfer    = s_valid & s_ready;
  assign hdr_wr  = (state == HDR)  & ~fifo_full;
  assign csum_wr = (state == CSUM) & ~fifo_full;
  // True when the word currently being transferred is payload word number MAX_LEN.
  assign at_max  = (count_q + 8'd1) == MaxLenC;

  // State register.
  always_ff @(posedge Wr_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; s_last wins over truncation on word MAX_LEN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = HDR;
      HDR:     if (!fifo_full) state_nxt = PAYLOAD;
      PAYLOAD: if (xfer) begin
                 if (s_last)      state_nxt = CSUM;
                 else if (at_max) state_nxt = DROP;
               end
      DROP:    if (xfer && s_last) state_nxt = CSUM;
      CSUM:    if (!fifo_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; FIFO strobe is gated by fifo_full with no register stage.
  always_comb begin
    s_ready    = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_data  = s_data;
    case (state)
      HDR: begin
        fifo_data  = SOF;
        fifo_wr_en = ~fifo_full;
      end
      PAYLOAD: begin
        s_ready    = ~fifo_full;
        fifo_data  = s_data;
        fifo_wr_en = s_valid & ~fifo_full;
      end
      DROP: s_ready = 1'b1;
      CSUM: begin
        fifo_data  = csum_q;
        fifo_wr_en = ~fifo_full;
      end
      default: ;
    endcase
  end

  // Per-frame checksum, payload count and truncation flag.
  always_ff @(posedge Wr_clk) begin
    if (reset) begin
      csum_q       <= '0;
      count_q      <= '0;
      trunc_flag_q <= 1'b0;
    end else if (hdr_wr) begin
      csum_q       <= '0;
      count_q      <= '0;
      trunc_flag_q <= 1'b0;
    end else if (state == PAYLOAD && xfer) begin
      csum_q  <= csum_q ^ s_data;
      count_q <= count_q + 8'd1;
      if (!s_last && at_max) trunc_flag_q <= 1'b1;
    end
  end

  // Completion pulses, asserted the cycle after the checksum write.
  always_ff @(posedge Wr_clk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      frame_done_q <= csum_wr;
      trunc_q      <= csum_wr & trunc_flag_q;
    end
  end

  assign frame_done = frame_done_q;
  assign trunc      = trunc_q;

`ifdef FRAMER_STATS_EN
  logic [7:0] frame_cnt_q;
  logic [7:0] trunc_cnt_q;

  // Saturating statistics, updated on the same edge that raises frame_done/trunc.
  always_ff @(posedge Wr_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else if (csum_wr) begin
      if (frame_cnt_q != 8'hFF) frame_cnt_q <= frame_cnt_q + 8'd1;
      if (trunc_flag_q && trunc_cnt_q != 8'hFF) trunc_cnt_q <= trunc_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign trunc_count = trunc_cnt_q;
`else
  assign frame_count = 8'd0;
  assign trunc_count = 8'd0;
`endif

endmodule
